// File: rtl/anc_sample_feeder.sv
// Sample-set FIFO feeding the ANC filter core with framed head_flag windows.
// Optional macro ANC_FEEDER_OFFSET_BIN_EN flips bit 13 of each channel at push.
module anc_sample_feeder #(
  parameter int FRAME_LEN  = 48,
  parameter int GAP_LEN    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [13:0] in_ch2,
  input  logic [13:0] in_ch3,
  input  logic [13:0] in_ref,
  input  logic        ovf_clr,
  output logic        in_ready,
  output logic [13:0] buffer_2,
  output logic [13:0] buffer_3,
  output logic [13:0] reff,
  output logic        head_flag,
  output logic        ovf,
  output logic [4:0]  fifo_level,
  output logic [1:0]  state_dbg
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH5    = 5'(FIFO_DEPTH);
  localparam logic [7:0]  FRAME_RLD = 8'(FRAME_LEN - 1);
  localparam logic [7:0]  GAP_RLD   = 8'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [41:0]     mem_q [FIFO_DEPTH];
  logic [13:0]     buf2_q, buf3_q, reff_q;
  logic            ovf_q, ovf_d;
  logic            push, drop, pop;
  logic [41:0]     wdata;

  // Handshake: a set transfers on a rising edge with in_valid and in_ready both high;
  // in_ready depends only on registered occupancy, so a same-edge pop never frees a slot.
  assign in_ready = (level_q < DEPTH5);
  assign push     = in_valid & in_ready;
  assign drop     = in_valid & ~in_ready;

`ifdef ANC_FEEDER_OFFSET_BIN_EN
  assign wdata = {in_ch2 ^ 14'h2000, in_ch3 ^ 14'h2000, in_ref ^ 14'h2000};
`else
  assign wdata = {in_ch2, in_ch3, in_ref};
`endif

  // Pops are decided from registered occupancy, so a push into an empty FIFO is never bypassed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != 5'd0) begin
          pop     = 1'b1;
          state_d = FRAME;
          cnt_d   = FRAME_RLD;
        end
      end
      FRAME: begin
        if (cnt_q == 8'd0) begin
          state_d = GAP;
          cnt_d   = GAP_RLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (level_q != 5'd0) begin
          pop     = 1'b1;
          state_d = FRAME;
          cnt_d   = FRAME_RLD;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    level_d = level_q + {4'd0, push} - {4'd0, pop};
    ovf_d   = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      level_q  <= 5'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      buf2_q   <= 14'd0;
      buf3_q   <= 14'd0;
      reff_q   <= 14'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        buf2_q   <= mem_q[rd_ptr_q][41:28];
        buf3_q   <= mem_q[rd_ptr_q][27:14];
        reff_q   <= mem_q[rd_ptr_q][13:0];
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign buffer_2   = buf2_q;
  assign buffer_3   = buf3_q;
  assign reff       = reff_q;
  assign head_flag  = (state_q == FRAME);
  assign ovf        = ovf_q;
  assign fifo_level = level_q;
  assign state_dbg  = state_q;

endmodule
